// File: rtl/cache_2way_fsm.sv
// 2-way set-associative write-back/write-allocate data cache controller with
// per-set 1-bit LRU, register-based storage and saturating access/miss counters.
module cache_2way_fsm #(
    parameter int INDEX_BITS     = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [63:0]                   cpu_req_addr_i,
    input  logic [63:0]                   cpu_req_data_i,
    input  logic                          cpu_req_rw_i,
    input  logic                          cpu_req_valid_i,
    input  logic [64*WORDS_PER_LINE-1:0]  mem_data_data_i,
    input  logic                          mem_data_ready_i,
    output logic                          mem_req_rw_o,
    output logic                          mem_req_valid_o,
    output logic [64*WORDS_PER_LINE-1:0]  mem_req_data_o,
    output logic [63:0]                   mem_req_addr_o,
    output logic [63:0]                   cpu_res_data_o,
    output logic                          cpu_res_ready_o,
    output logic [CNT_W-1:0]              access_cnt_o,
    output logic [CNT_W-1:0]              miss_cnt_o
);
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int LINE_W    = 64 * WORDS_PER_LINE;
    localparam int WSEL_BITS = $clog2(WORDS_PER_LINE);
    localparam int WSEL_W    = (WSEL_BITS > 0) ? WSEL_BITS : 1;
    localparam int OFF_BITS  = 3 + WSEL_BITS;
    localparam int TAG_W     = 64 - INDEX_BITS - OFF_BITS;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t state_reg, state_next;
    logic   victim_reg, victim_next;
    logic   first_cmp_reg, first_cmp_next;

    logic [SETS-1:0]   valid_reg [2];
    logic [SETS-1:0]   dirty_reg [2];
    logic [SETS-1:0]   lru_reg;
    logic [TAG_W-1:0]  tag_reg  [2][SETS];
    logic [LINE_W-1:0] line_reg [2][SETS];

    logic [CNT_W-1:0]  access_cnt_reg, miss_cnt_reg;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic [WSEL_W-1:0]     word_sel;
    logic                  unused_addr_bits;

    assign index            = cpu_req_addr_i[OFF_BITS +: INDEX_BITS];
    assign tag              = cpu_req_addr_i[63 -: TAG_W];
    assign unused_addr_bits = ^cpu_req_addr_i[2:0];

    generate
        if (WSEL_BITS > 0) begin : g_wsel
            assign word_sel = cpu_req_addr_i[3 +: WSEL_W];
        end else begin : g_wsel_single
            assign word_sel = '0;
        end
    endgenerate

    // Combinational view of the indexed set, one entry per way.
    logic [LINE_W-1:0] set_line [2];
    logic [TAG_W-1:0]  set_tag  [2];
    logic [1:0]        hit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign set_line[gi] = line_reg[gi][index];
            assign set_tag[gi]  = tag_reg[gi][index];
            assign hit[gi]      = valid_reg[gi][index] && (set_tag[gi] == tag);
        end
    endgenerate

    logic              hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] merged_line;
    logic [63:0]       hit_words [WORDS_PER_LINE];

    assign hit_way  = hit[1];
    assign hit_line = set_line[hit_way];

    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            assign hit_words[gi] = hit_line[gi*64 +: 64];
            assign merged_line[gi*64 +: 64] =
                (word_sel == WSEL_W'(gi)) ? cpu_req_data_i : hit_line[gi*64 +: 64];
        end
    endgenerate

    // Invalid ways are filled first so a live line is never evicted needlessly.
    logic miss_victim;
    assign miss_victim = !valid_reg[0][index] ? 1'b0 :
                         !valid_reg[1][index] ? 1'b1 : lru_reg[index];

    logic hit_upd, fill_upd, acc_inc, miss_inc;

    always_comb begin
        state_next      = state_reg;
        victim_next     = victim_reg;
        first_cmp_next  = first_cmp_reg;
        hit_upd         = 1'b0;
        fill_upd        = 1'b0;
        acc_inc         = 1'b0;
        miss_inc        = 1'b0;
        mem_req_rw_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_data_o  = '0;
        mem_req_addr_o  = '0;
        cpu_res_ready_o = 1'b0;
        cpu_res_data_o  = hit_words[word_sel];
        case (state_reg)
            IDLE: begin
                if (cpu_req_valid_i) begin
                    state_next     = COMPARE;
                    first_cmp_next = 1'b1;
                    acc_inc        = 1'b1;
                end
            end
            COMPARE: begin
                if (!cpu_req_valid_i) begin
                    state_next = IDLE;
                end else if (|hit) begin
                    cpu_res_ready_o = 1'b1;
                    hit_upd         = 1'b1;
                    state_next      = IDLE;
                end else begin
                    miss_inc       = first_cmp_reg;
                    first_cmp_next = 1'b0;
                    victim_next    = miss_victim;
                    state_next     = (valid_reg[miss_victim][index] && dirty_reg[miss_victim][index])
                                     ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                mem_req_valid_o = 1'b1;
                mem_req_rw_o    = 1'b1;
                mem_req_addr_o  = {set_tag[victim_reg], index, {OFF_BITS{1'b0}}};
                mem_req_data_o  = set_line[victim_reg];
                if (mem_data_ready_i) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {cpu_req_addr_i[63:OFF_BITS], {OFF_BITS{1'b0}}};
                if (mem_data_ready_i) begin
                    fill_upd   = 1'b1;
                    state_next = COMPARE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            victim_reg     <= 1'b0;
            first_cmp_reg  <= 1'b0;
            valid_reg[0]   <= '0;
            valid_reg[1]   <= '0;
            dirty_reg[0]   <= '0;
            dirty_reg[1]   <= '0;
            lru_reg        <= '0;
            access_cnt_reg <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            victim_reg    <= victim_next;
            first_cmp_reg <= first_cmp_next;
            if (hit_upd) begin
                lru_reg[index] <= ~hit_way;
                if (cpu_req_rw_i) dirty_reg[hit_way][index] <= 1'b1;
            end
            if (fill_upd) begin
                valid_reg[victim_reg][index] <= 1'b1;
                dirty_reg[victim_reg][index] <= 1'b0;
            end
            if (acc_inc && (access_cnt_reg != {CNT_W{1'b1}}))
                access_cnt_reg <= access_cnt_reg + 1'b1;
            if (miss_inc && (miss_cnt_reg != {CNT_W{1'b1}}))
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
    end

    // Tags and line data carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill_upd) begin
                line_reg[victim_reg][index] <= mem_data_data_i;
                tag_reg[victim_reg][index]  <= tag;
            end else if (hit_upd && cpu_req_rw_i) begin
                line_reg[hit_way][index] <= merged_line;
            end
        end
    end

    assign access_cnt_o = access_cnt_reg;
    assign miss_cnt_o   = miss_cnt_reg;

endmodule

// File: tb/tb_cache_2way_fsm.sv
// Directed bench for cache_2way_fsm: the bench acts as CPU and memory and
// checks handshakes, data, LRU victim choice, write-back and reset abort.
module tb_cache_2way_fsm;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [63:0]  cpu_req_addr_i = '0;
    logic [63:0]  cpu_req_data_i = '0;
    logic         cpu_req_rw_i = 1'b0;
    logic         cpu_req_valid_i = 1'b0;
    logic [255:0] mem_data_data_i = '0;
    logic         mem_data_ready_i = 1'b0;
    logic         mem_req_rw_o;
    logic         mem_req_valid_o;
    logic [255:0] mem_req_data_o;
    logic [63:0]  mem_req_addr_o;
    logic [63:0]  cpu_res_data_o;
    logic         cpu_res_ready_o;
    logic [31:0]  access_cnt_o;
    logic [31:0]  miss_cnt_o;

    int tests = 0;
    int fails = 0;

    cache_2way_fsm dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_addr_i(cpu_req_addr_i), .cpu_req_data_i(cpu_req_data_i),
        .cpu_req_rw_i(cpu_req_rw_i), .cpu_req_valid_i(cpu_req_valid_i),
        .mem_data_data_i(mem_data_data_i), .mem_data_ready_i(mem_data_ready_i),
        .mem_req_rw_o(mem_req_rw_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_data_o(mem_req_data_o), .mem_req_addr_o(mem_req_addr_o),
        .cpu_res_data_o(cpu_res_data_o), .cpu_res_ready_o(cpu_res_ready_o),
        .access_cnt_o(access_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [63:0] w0, input logic [63:0] w1,
                                             input logic [63:0] w2, input logic [63:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic req(input logic [63:0] a, input logic rw, input logic [63:0] d);
        @(negedge clk_i);
        cpu_req_addr_i  = a;
        cpu_req_rw_i    = rw;
        cpu_req_data_i  = d;
        cpu_req_valid_i = 1'b1;
    endtask

    // Wait for a memory request, check it is held, then answer with one ready pulse.
    task automatic serve(input string tag, input logic exp_rw, input logic [63:0] exp_addr,
                         input logic [255:0] line, output logic [255:0] req_data);
        int n = 0;
        while (mem_req_valid_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, " mem valid"}, 64'(mem_req_valid_o), 64'd1);
        chk({tag, " mem rw"}, 64'(mem_req_rw_o), 64'(exp_rw));
        chk({tag, " mem addr"}, mem_req_addr_o, exp_addr);
        repeat (2) @(negedge clk_i);
        chk({tag, " mem valid held"}, 64'(mem_req_valid_o), 64'd1);
        chk({tag, " mem addr held"}, mem_req_addr_o, exp_addr);
        req_data         = mem_req_data_o;
        mem_data_data_i  = line;
        mem_data_ready_i = 1'b1;
        @(negedge clk_i);
        mem_data_ready_i = 1'b0;
    endtask

    task automatic respond(input string tag, input logic chk_data, input logic [63:0] exp_data,
                           output int lat, output logic saw_mem);
        int n = 0;
        saw_mem = 1'b0;
        while (cpu_res_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
            if (mem_req_valid_o === 1'b1) saw_mem = 1'b1;
        end
        chk({tag, " res ready"}, 64'(cpu_res_ready_o), 64'd1);
        if (chk_data) chk({tag, " res data"}, cpu_res_data_o, exp_data);
        lat = n;
        @(posedge clk_i);
        #1 cpu_req_valid_i = 1'b0;
    endtask

    task automatic counters(input string tag, input int acc, input int miss);
        @(negedge clk_i);
        chk({tag, " access_cnt"}, 64'(access_cnt_o), 64'(acc));
        chk({tag, " miss_cnt"}, 64'(miss_cnt_o), 64'(miss));
    endtask

    task automatic hit_read(input string tag, input logic [63:0] a, input logic [63:0] exp);
        int lat;
        logic saw;
        req(a, 1'b0, 64'd0);
        respond(tag, 1'b1, exp, lat, saw);
        $display("[TB] %s: read 0x%0h -> 0x%0h latency %0d", tag, a, cpu_res_data_o, lat);
        chk({tag, " hit latency"}, 64'(lat), 64'd1);
        chk({tag, " no mem req"}, 64'(saw), 64'd0);
    endtask

    initial begin
        int lat;
        logic saw;
        logic [255:0] rd;

        repeat (2) @(negedge clk_i);
        chk("reset res_ready", 64'(cpu_res_ready_o), 64'd0);
        chk("reset mem_valid", 64'(mem_req_valid_o), 64'd0);
        chk("reset mem_rw", 64'(mem_req_rw_o), 64'd0);
        chk("reset mem_addr", mem_req_addr_o, 64'd0);
        chk("reset mem_data", mem_req_data_o[63:0], 64'd0);
        chk("reset access_cnt", 64'(access_cnt_o), 64'd0);
        chk("reset miss_cnt", 64'(miss_cnt_o), 64'd0);
        rst_i = 1'b0;

        // 1: cold read miss in set 8
        req(64'h100, 1'b0, 64'd0);
        serve("s1 fetch", 1'b0, 64'h100, mk_line(64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD), rd);
        respond("s1", 1'b1, 64'hAAAA, lat, saw);
        $display("[TB] s1: read 0x100 -> 0x%0h", cpu_res_data_o);
        counters("s1", 1, 1);

        // 2: hit on word1 of the same line
        hit_read("s2", 64'h108, 64'hBBBB);
        counters("s2", 2, 1);

        // 3: fill other way, refresh 0x100, evict LRU way1 (0x300, clean)
        req(64'h300, 1'b0, 64'd0);
        serve("s3 fetch 300", 1'b0, 64'h300, mk_line(64'h3000, 64'h3001, 64'h3002, 64'h3003), rd);
        respond("s3 300", 1'b1, 64'h3000, lat, saw);
        $display("[TB] s3: read 0x300 -> 0x%0h", cpu_res_data_o);
        hit_read("s3 100a", 64'h100, 64'hAAAA);
        req(64'h500, 1'b0, 64'd0);
        serve("s3 fetch 500", 1'b0, 64'h500, mk_line(64'h5000, 64'h5001, 64'h5002, 64'h5003), rd);
        respond("s3 500", 1'b1, 64'h5000, lat, saw);
        $display("[TB] s3: read 0x500 -> 0x%0h", cpu_res_data_o);
        hit_read("s3 100b", 64'h100, 64'hAAAA);
        counters("s3", 6, 3);

        // 4: dirty 0x100, then force its eviction
        req(64'h100, 1'b1, 64'h1234);
        respond("s4 write", 1'b0, 64'd0, lat, saw);
        $display("[TB] s4: write 0x100 = 0x1234 latency %0d", lat);
        chk("s4 write hit latency", 64'(lat), 64'd1);
        req(64'h300, 1'b0, 64'd0);
        serve("s4 fetch 300", 1'b0, 64'h300, mk_line(64'h3000, 64'h3001, 64'h3002, 64'h3003), rd);
        respond("s4 300", 1'b1, 64'h3000, lat, saw);
        req(64'h500, 1'b0, 64'd0);
        serve("s4 wb 100", 1'b1, 64'h100, 256'd0, rd);
        $display("[TB] s4: write-back 0x100 word0 0x%0h word1 0x%0h", rd[63:0], rd[127:64]);
        chk("s4 wb word0", rd[63:0], 64'h1234);
        chk("s4 wb word1", rd[127:64], 64'hBBBB);
        serve("s4 fetch 500", 1'b0, 64'h500, mk_line(64'h5555, 64'h5556, 64'h5557, 64'h5558), rd);
        respond("s4 500", 1'b1, 64'h5555, lat, saw);
        counters("s4", 9, 5);

        // 5: write miss in set 0, merge, read back, then evict it
        req(64'h208, 1'b1, 64'h55);
        serve("s5 fetch 200", 1'b0, 64'h200, mk_line(64'h2000, 64'h2222, 64'h2002, 64'h2003), rd);
        respond("s5 write", 1'b0, 64'd0, lat, saw);
        $display("[TB] s5: write miss 0x208 = 0x55 completed");
        hit_read("s5 readback", 64'h208, 64'h55);
        req(64'h400, 1'b0, 64'd0);
        serve("s5 fetch 400", 1'b0, 64'h400, mk_line(64'h4000, 64'h4001, 64'h4002, 64'h4003), rd);
        respond("s5 400", 1'b1, 64'h4000, lat, saw);
        req(64'h600, 1'b0, 64'd0);
        serve("s5 wb 200", 1'b1, 64'h200, 256'd0, rd);
        $display("[TB] s5: write-back 0x200 word0 0x%0h word1 0x%0h", rd[63:0], rd[127:64]);
        chk("s5 wb word0", rd[63:0], 64'h2000);
        chk("s5 wb word1", rd[127:64], 64'h55);
        serve("s5 fetch 600", 1'b0, 64'h600, mk_line(64'h6000, 64'h6001, 64'h6002, 64'h6003), rd);
        respond("s5 600", 1'b1, 64'h6000, lat, saw);
        counters("s5", 13, 8);

        // 6: reset while ALLOCATE is pending, then a stray ready in IDLE
        req(64'h100, 1'b0, 64'd0);
        for (int n = 0; n < 50 && mem_req_valid_o !== 1'b1; n++) @(negedge clk_i);
        chk("s6 alloc before reset", 64'(mem_req_valid_o), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        cpu_req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("s6 mem_valid after reset", 64'(mem_req_valid_o), 64'd0);
        chk("s6 res_ready after reset", 64'(cpu_res_ready_o), 64'd0);
        chk("s6 access_cnt after reset", 64'(access_cnt_o), 64'd0);
        chk("s6 miss_cnt after reset", 64'(miss_cnt_o), 64'd0);
        $display("[TB] s6: reset during ALLOCATE, mem_valid %0b", mem_req_valid_o);
        rst_i = 1'b0;
        @(negedge clk_i);
        mem_data_data_i  = mk_line(64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD);
        mem_data_ready_i = 1'b1;
        @(negedge clk_i);
        mem_data_ready_i = 1'b0;
        chk("s6 stray ready ignored", 64'(mem_req_valid_o), 64'd0);
        req(64'h100, 1'b0, 64'd0);
        serve("s6 fetch 100", 1'b0, 64'h100, mk_line(64'h7777, 64'h7778, 64'h7779, 64'h777A), rd);
        respond("s6", 1'b1, 64'h7777, lat, saw);
        $display("[TB] s6: read 0x100 after reset -> 0x%0h", cpu_res_data_o);
        counters("s6", 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
